// File: rtl/spi_master_ctrl.sv
// SPI initiator for the 16-bit sensor-register slave: one command at a time,
// MSB-first 16-bit frames, optional in-frame spi_ldb load strobe, 11-bit readback.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [3:0]  cmd_addr,
  input  logic [10:0] cmd_wdata,
  input  logic [2:0]  cmd_ldb,
  output logic        rsp_valid,
  output logic [10:0] rsp_rdata,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_csb,
  output logic        spi_ldb
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   frame_q, frame_d;
  logic [10:0]   rx_q, rx_d;
  logic          rw_q, rw_d;
  logic [2:0]    ldb_sel_q, ldb_sel_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          csb_q, csb_d;
  logic          ldb_q, ldb_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [10:0]   rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    gcnt_d      = gcnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    ldb_sel_d   = ldb_sel_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    csb_d       = csb_q;
    ldb_d       = ldb_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_LEAD;
          hcnt_d    = '0;
          frame_d   = {cmd_rw, cmd_addr, cmd_rw ? 11'd0 : cmd_wdata};
          rw_d      = cmd_rw;
          // Codes 6..7 are folded to 0 so they can never match a bit position.
          ldb_sel_d = (cmd_ldb >= 3'd1 && cmd_ldb <= 3'd5) ? cmd_ldb : 3'd0;
          rx_d      = '0;
          csb_d     = 1'b0;
          ready_d   = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_LEAD: begin
        if (hcnt_q == H_LAST) begin
          state_d = S_HI;
          hcnt_d  = '0;
          bit_d   = 5'd0;
          sclk_d  = 1'b1;
          mosi_d  = frame_q[15];
          frame_d = {frame_q[14:0], 1'b0};
          ldb_d   = (ldb_sel_q != 3'd1);
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_HI: begin
        if (hcnt_q == H_LAST) begin
          state_d = S_LO;
          hcnt_d  = '0;
          sclk_d  = 1'b0;
          rx_d    = {rx_q[9:0], spi_miso};
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_LO: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (bit_q == 5'd15) begin
            state_d = S_GAP;
            gcnt_d  = '0;
            csb_d   = 1'b1;
            mosi_d  = 1'b0;
            ldb_d   = 1'b1;
            if (rw_q) begin
              rsp_valid_d = 1'b1;
              rdata_d     = rx_q;
            end else begin
              rsp_valid_d = 1'b0;
            end
          end else begin
            state_d = S_HI;
            bit_d   = bit_q + 5'd1;
            sclk_d  = 1'b1;
            mosi_d  = frame_q[15];
            frame_d = {frame_q[14:0], 1'b0};
            // Next bit position is bit_q+2 (bit_q counts from 0).
            ldb_d   = ({2'b00, ldb_sel_q} != (bit_q + 5'd2));
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == G_LAST) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
          ready_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = '0;
        gcnt_d  = '0;
        bit_d   = 5'd0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        csb_d   = 1'b1;
        ldb_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      gcnt_q      <= '0;
      bit_q       <= 5'd0;
      frame_q     <= 16'd0;
      rx_q        <= 11'd0;
      rw_q        <= 1'b0;
      ldb_sel_q   <= 3'd0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csb_q       <= 1'b1;
      ldb_q       <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 11'd0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      gcnt_q      <= gcnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      ldb_sel_q   <= ldb_sel_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      csb_q       <= csb_d;
      ldb_q       <= ldb_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_csb   = csb_q;
  assign spi_ldb   = ldb_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: per-cycle comparison of every output
// against a timing-formula model, with a randomized slave driving spi_miso.
module tb_spi_master_ctrl;

  localparam int H   = 4;
  localparam int GAP = 8;
  localparam int LAST = 1 + 33 * H + GAP;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [3:0]  cmd_addr;
  logic [10:0] cmd_wdata;
  logic [2:0]  cmd_ldb;
  logic        rsp_valid;
  logic [10:0] rsp_rdata;
  logic        busy;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_csb;
  logic        spi_ldb;

  int          tests = 0;
  int          fails = 0;
  logic [10:0] last_rd = 11'd0;
  bit          prev_hold = 1'b0;

  spi_master_ctrl #(.CLK_DIV(H), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ldb(cmd_ldb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_csb(spi_csb), .spi_ldb(spi_ldb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_csb"},   {15'd0, spi_csb},   16'd1);
    check({tag, "_sclk"},  {15'd0, spi_sclk},  16'd0);
    check({tag, "_mosi"},  {15'd0, spi_mosi},  16'd0);
    check({tag, "_ldb"},   {15'd0, spi_ldb},   16'd1);
    check({tag, "_rv"},    {15'd0, rsp_valid}, 16'd0);
    check({tag, "_rdata"}, {5'd0, rsp_rdata},  16'd0);
    check({tag, "_ready"}, {15'd0, cmd_ready}, 16'd1);
    check({tag, "_busy"},  {15'd0, busy},      16'd0);
  endtask

  // One command from acceptance to the cycle cmd_ready returns (or to abort_t).
  task automatic run_frame(input logic rw, input logic [3:0] addr, input logic [10:0] wdata,
                           input logic [2:0] ldb, input logic [15:0] rxw,
                           input bit hold, input int abort_t);
    logic [15:0] f;
    logic [15:0] mosi_cap;
    logic [10:0] exp_rd;
    int          rises;
    logic        prev_sclk;
    int          wait_n;
    int          u;
    int          p;
    logic        e_sclk, e_mosi, e_ldb, e_csb, e_rv, e_rdy;
    bit          in_shift;

    f = {rw, addr, rw ? 11'd0 : wdata};
    wait_n = 0;
    while (cmd_ready !== 1'b1 && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("ready_wait", {15'd0, cmd_ready}, 16'd1);
    if (prev_hold) check("b2b_accept_delay", 16'(wait_n), 16'd0);
    prev_hold = hold;

    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_ldb   = ldb;
    cmd_valid = 1'b1;
    spi_miso  = 1'($urandom);
    @(negedge clk);

    prev_sclk = 1'b0;
    rises     = 0;
    mosi_cap  = 16'd0;
    for (int t = 1; t <= LAST; t++) begin
      in_shift = (t >= 1 + H) && (t <= 33 * H);
      u = t - 1 - H;
      p = in_shift ? (u / (2 * H) + 1) : 0;
      e_csb  = !(t <= 33 * H);
      e_sclk = in_shift && ((u % (2 * H)) < H);
      e_mosi = in_shift ? f[16 - p] : 1'b0;
      e_ldb  = !(in_shift && ldb >= 3'd1 && ldb <= 3'd5 && p == int'(ldb));
      e_rv   = rw && (t == 1 + 33 * H);
      e_rdy  = (t == LAST);
      exp_rd = (rw && t >= 1 + 33 * H) ? rxw[10:0] : last_rd;

      check("csb",   {15'd0, spi_csb},   {15'd0, e_csb});
      check("sclk",  {15'd0, spi_sclk},  {15'd0, e_sclk});
      check("mosi",  {15'd0, spi_mosi},  {15'd0, e_mosi});
      check("ldb",   {15'd0, spi_ldb},   {15'd0, e_ldb});
      check("rv",    {15'd0, rsp_valid}, {15'd0, e_rv});
      check("rdata", {5'd0, rsp_rdata},  {5'd0, exp_rd});
      check("ready", {15'd0, cmd_ready}, {15'd0, e_rdy});
      check("busy",  {15'd0, busy},      {15'd0, !e_rdy});

      if (t == abort_t) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        rst = 1'b0;
        last_rd = 11'd0;
        prev_hold = 1'b0;
        return;
      end

      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = spi_sclk;
      if (in_shift && (u % (2 * H)) == H - 1) mosi_cap = {mosi_cap[14:0], spi_mosi};

      // Slave holds the bit through the high phase; garbage elsewhere.
      if (in_shift && ((u % (2 * H)) < H)) spi_miso = rxw[16 - p];
      else spi_miso = 1'($urandom);

      if (t < LAST) begin
        cmd_valid = hold ? 1'b1 : 1'($urandom);
        cmd_rw    = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = 11'($urandom);
        cmd_ldb   = 3'($urandom);
        @(negedge clk);
      end else begin
        cmd_valid = hold;
      end
    end
    check("mosi_frame", mosi_cap, f);
    check("sclk_rises", 16'(rises), 16'd16);
    if (rw) last_rd = rxw[10:0];
  endtask

  initial begin
    logic [15:0] r;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = 4'd0;
    cmd_wdata = 11'd0;
    cmd_ldb   = 3'd0;
    spi_miso  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Write addr 3 / 0x5A5 (frame 0x1DA5), no strobe.
    run_frame(1'b0, 4'd3, 11'h5A5, 3'd0, 16'($urandom), 1'b0, 0);
    // Read addr 0xA (frame 0xD000), slave returns 0x3C7.
    r = 16'($urandom);
    r[10:0] = 11'h3C7;
    run_frame(1'b1, 4'hA, 11'($urandom), 3'd0, r, 1'b0, 0);
    // Load strobe at bit 3, then codes 0 and 6; readback held through writes.
    run_frame(1'b0, 4'($urandom), 11'($urandom), 3'd3, 16'($urandom), 1'b0, 0);
    run_frame(1'b0, 4'($urandom), 11'($urandom), 3'd0, 16'($urandom), 1'b0, 0);
    run_frame(1'b1, 4'($urandom), 11'($urandom), 3'd6, 16'($urandom), 1'b0, 0);
    run_frame(1'b0, 4'($urandom), 11'($urandom), 3'd5, 16'($urandom), 1'b0, 0);
    run_frame(1'b0, 4'($urandom), 11'($urandom), 3'd1, 16'($urandom), 1'b0, 0);

    // Back-to-back with cmd_valid held high.
    run_frame(1'b1, 4'($urandom), 11'($urandom), 3'd2, 16'($urandom), 1'b1, 0);
    run_frame(1'b0, 4'($urandom), 11'($urandom), 3'd4, 16'($urandom), 1'b0, 0);

    // Reset at the rising edge of bit 9 of a read, then a clean read.
    run_frame(1'b1, 4'($urandom), 11'($urandom), 3'd0, 16'($urandom), 1'b0, 1 + 17 * H);
    run_frame(1'b1, 4'($urandom), 11'($urandom), 3'd0, 16'($urandom), 1'b0, 0);

    // Randomized commands.
    for (int i = 0; i < 6; i++) begin
      run_frame(1'($urandom), 4'($urandom), 11'($urandom), 3'($urandom),
                16'($urandom), 1'($urandom), 0);
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
